// File: rtl/seg_display_scheduler_if.sv
// -----------------------------------------------------------------------------
// seg_display_scheduler_if
//
// Purpose: request/acknowledge bundle between the display requesters and the
// seven-segment display scheduler.
//
// Handshake: a requester raises src_valid[i] with its value on
// src_data[16*i+15:16*i] and holds both until it sees src_ack[i]. src_ack[i]
// is a one-cycle pulse marking the cycle in which the scheduler samples
// src_data for requester i. A transfer completes on the rising clock edge that
// ends a cycle in which src_valid[i] and src_ack[i] are both high.
//
// Signals:
//   src_valid  N_SRC     per-requester display request (master -> slave)
//   src_data   16*N_SRC  binary value of each requester (master -> slave)
//   src_ack    N_SRC     sample pulse (slave -> master)
// -----------------------------------------------------------------------------
interface seg_display_scheduler_if #(
    parameter int N_SRC = 4
);
    logic [N_SRC-1:0]    src_valid;
    logic [16*N_SRC-1:0] src_data;
    logic [N_SRC-1:0]    src_ack;

    modport master (output src_valid, output src_data, input src_ack);
    modport slave  (input src_valid, input src_data, output src_ack);
endinterface

// File: rtl/seg_display_scheduler.sv
// -----------------------------------------------------------------------------
// seg_display_scheduler
//
// Purpose: time-shares a 4-digit seven-segment display between N_SRC
// requesters. Grants round-robin, converts the granted 16-bit value to BCD
// with a sequential shift-add-3 engine, holds it for DWELL_CYCLES and drives
// the multiplexed anode/segment pins from a double-buffered digit register.
//
// Ports:
//   clk_100mhz      in   board clock, rising edge
//   reset           in   asynchronous active-high reset
//   src             if   request bundle (slave modport)
//   active_src      out  index of the requester owning the display
//   busy            out  high while a BCD conversion is in progress
//   Anode_Activate  out  active-low digit enables, bit 3 = thousands
//   LED_out         out  active-low segments, bit 6 = a ... bit 0 = g
//   dbg_state_o     out  current FSM state encoding (ARB=0 LOAD=1 SHIFT=2
//                        DONE=3 HOLD=4)
//
// Build option: define SEG_LEAD_BLANK_EN to blank leading-zero digits (the
// ones digit always shows). Without it all four digits are always driven.
// -----------------------------------------------------------------------------
module seg_display_scheduler #(
    parameter int N_SRC        = 4,
    parameter int DWELL_CYCLES = 100000000,
    parameter int REFRESH_BITS = 20
) (
    input  logic                     clk_100mhz,
    input  logic                     reset,
    seg_display_scheduler_if.slave   src,
    output logic [$clog2(N_SRC)-1:0] active_src,
    output logic                     busy,
    output logic [3:0]               Anode_Activate,
    output logic [6:0]               LED_out,
    output logic [2:0]               dbg_state_o
);
    localparam int IDX_W = $clog2(N_SRC);
    localparam int DW_W  = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DW_W-1:0]  DWELL_LOAD = DW_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_RST   = IDX_W'(N_SRC - 1);

    typedef enum logic [2:0] {
        ARB   = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        DONE  = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        last_grant_q;
    logic [IDX_W-1:0]        active_src_q;
    logic [15:0]             bin_q;
    logic [19:0]             bcd_q;       // five digits: 65535 needs them
    logic [3:0]              bit_cnt_q;
    logic [15:0]             disp_q;      // display buffer, thousands in [15:12]
    logic                    ovf_q;
    logic [DW_W-1:0]         dwell_q;
    logic [REFRESH_BITS-1:0] refresh_q;

    // Add 3 to every BCD nibble >= 5 so the following left shift carries
    // correctly into the next decimal digit.
    function automatic logic [19:0] add3(input logic [19:0] b);
        logic [19:0] r;
        r = b;
        for (int n = 0; n < 5; n++) begin
            if (b[4*n +: 4] >= 4'd5) r[4*n +: 4] = b[4*n +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b0000001;
            4'd1:    seg_code = 7'b1001111;
            4'd2:    seg_code = 7'b0010010;
            4'd3:    seg_code = 7'b0000110;
            4'd4:    seg_code = 7'b1001100;
            4'd5:    seg_code = 7'b0100100;
            4'd6:    seg_code = 7'b0100000;
            4'd7:    seg_code = 7'b0001111;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0000100;
            default: seg_code = 7'b1111111;
        endcase
    endfunction

    // Round-robin search starting just after the last grant.
    logic             found;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] cand;
    always_comb begin
        found  = 1'b0;
        winner = last_grant_q;
        cand   = last_grant_q;
        for (int i = 1; i <= N_SRC; i++) begin
            cand = IDX_W'((int'(last_grant_q) + i) % N_SRC);
            if (!found && src.src_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) state_q <= ARB;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        src.src_ack = '0;
        busy        = 1'b0;
        case (state_q)
            ARB:   if (found) state_d = LOAD;
            LOAD: begin
                src.src_ack = {{(N_SRC-1){1'b0}}, 1'b1} << last_grant_q;
                busy        = 1'b1;
                state_d     = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (bit_cnt_q == 4'd15) state_d = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                state_d = HOLD;
            end
            HOLD:    if (dwell_q == '0) state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            last_grant_q <= LAST_RST;
            active_src_q <= '0;
            bin_q        <= '0;
            bcd_q        <= '0;
            bit_cnt_q    <= '0;
            disp_q       <= '0;
            ovf_q        <= 1'b0;
            dwell_q      <= '0;
        end else begin
            case (state_q)
                ARB: if (found) last_grant_q <= winner;
                LOAD: begin
                    bin_q        <= src.src_data[16*last_grant_q +: 16];
                    active_src_q <= last_grant_q;
                    bcd_q        <= '0;
                    bit_cnt_q    <= '0;
                end
                SHIFT: begin
                    {bcd_q, bin_q} <= {add3(bcd_q), bin_q} << 1;
                    bit_cnt_q      <= bit_cnt_q + 4'd1;
                end
                DONE: begin
                    // Whole buffer copied at once so the display never shows
                    // a mix of old and new digits.
                    disp_q  <= bcd_q[15:0];
                    ovf_q   <= (bcd_q[19:16] != 4'd0);
                    dwell_q <= DWELL_LOAD;
                end
                HOLD: if (dwell_q != '0) dwell_q <= dwell_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) refresh_q <= '0;
        else       refresh_q <= refresh_q + 1'b1;
    end

    // lead_zero[k] marks digit k (3 = thousands) as a leading zero.
    logic [3:0] lead_zero;
`ifdef SEG_LEAD_BLANK_EN
    assign lead_zero[3] = (disp_q[15:12] == 4'd0);
    assign lead_zero[2] = lead_zero[3] && (disp_q[11:8] == 4'd0);
    assign lead_zero[1] = lead_zero[2] && (disp_q[7:4] == 4'd0);
    assign lead_zero[0] = 1'b0;
`else
    assign lead_zero = 4'b0000;
`endif

    logic [1:0] sel;
    logic [3:0] digit;
    logic       blank;
    assign sel = refresh_q[REFRESH_BITS-1 -: 2];

    always_comb begin
        Anode_Activate = 4'b0111;
        digit          = disp_q[15:12];
        blank          = lead_zero[3];
        case (sel)
            2'd0: begin Anode_Activate = 4'b0111; digit = disp_q[15:12]; blank = lead_zero[3]; end
            2'd1: begin Anode_Activate = 4'b1011; digit = disp_q[11:8];  blank = lead_zero[2]; end
            2'd2: begin Anode_Activate = 4'b1101; digit = disp_q[7:4];   blank = lead_zero[1]; end
            default: begin Anode_Activate = 4'b1110; digit = disp_q[3:0]; blank = lead_zero[0]; end
        endcase
        if (ovf_q)      LED_out = 7'b1111110;
        else if (blank) LED_out = 7'b1111111;
        else            LED_out = seg_code(digit);
    end

    assign active_src  = active_src_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_seg_display_scheduler.sv
module tb_seg_display_scheduler;
  localparam int N_SRC = 4;
  localparam int DWELL = 4;
  localparam int RB    = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seg_display_scheduler_if #(.N_SRC(N_SRC)) src_if ();
  logic [1:0] active_src;
  logic       busy;
  logic [3:0] anode;
  logic [6:0] led;
  logic [2:0] dbg_state;

  seg_display_scheduler #(
    .N_SRC(N_SRC), .DWELL_CYCLES(DWELL), .REFRESH_BITS(RB)
  ) dut (
    .clk_100mhz(clk), .reset(reset), .src(src_if.slave),
    .active_src(active_src), .busy(busy), .Anode_Activate(anode),
    .LED_out(led), .dbg_state_o(dbg_state)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  int n_acks    = 0;
  logic [RB-1:0] ref_cnt;
  logic [1:0] exp_q[$];
  int ack_cyc_q[$];
  logic [1:0] mon_exp;
  logic [15:0] prev_bcd;
  logic prev_ovf;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or posedge reset)
    if (reset) ref_cnt <= '0;
    else       ref_cnt <= ref_cnt + 1'b1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  function automatic logic [3:0] exp_anode(input logic [1:0] slot);
    case (slot)
      2'd0: return 4'b0111;
      2'd1: return 4'b1011;
      2'd2: return 4'b1101;
      default: return 4'b1110;
    endcase
  endfunction

  function automatic logic [6:0] exp_led(input logic [1:0] slot, input logic [15:0] bcd, input logic ovf);
    logic [3:0] dig;
    dig = bcd[15 - 4*slot -: 4];
    if (ovf) return 7'b1111110;
`ifdef SEG_LEAD_BLANK_EN
    begin
      int lz;
      lz = 0;
      for (int k = 0; k < 3; k++)
        if (bcd[15 - 4*k -: 4] == 4'd0 && lz == k) lz = k + 1;
      if (int'(slot) < lz) return 7'b1111111;
    end
`endif
    return seg_of(dig);
  endfunction

  // scoreboard: every ack must match the next expected grant
  always @(negedge clk) begin
    if (!reset && src_if.src_ack !== '0) begin
      ack_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) check("unexpected_ack", 32'(src_if.src_ack), 0);
      else begin
        mon_exp = exp_q.pop_front();
        check("ack_grant", 32'(src_if.src_ack), 32'(4'b0001 << mon_exp));
      end
    end
  end

  // driver tasks
  task automatic wait_until(input int t);
    while (cyc < t) begin @(negedge clk); #1; end
  endtask

  task automatic wait_ack(output int l);
    int guard;
    guard = 0;
    while (ack_cyc_q.size() <= n_acks && guard < 200) begin
      @(negedge clk); #1; guard++;
    end
    if (ack_cyc_q.size() <= n_acks) begin
      check("ack_timeout", ack_cyc_q.size(), n_acks + 1);
      l = cyc;
    end else l = ack_cyc_q[n_acks];
    n_acks++;
  endtask

  task automatic check_cycles(input string name, input int n, input logic [15:0] bcd, input logic ovf);
    for (int i = 0; i < n; i++) begin
      check({name, "_anode"}, 32'(anode), 32'(exp_anode(ref_cnt[RB-1 -: 2])));
      check({name, "_led"}, 32'(led), 32'(exp_led(ref_cnt[RB-1 -: 2], bcd, ovf)));
      @(negedge clk); #1;
    end
  endtask

  typedef struct {
    logic [15:0] value;
    logic [15:0] exp_bcd;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[9];
  logic [15:0] rr_bcd[4];

  initial begin
    int l, prev_l;
    vecs[0] = '{16'd6765,  16'h6765, 1'b0};
    vecs[1] = '{16'd7,     16'h0007, 1'b0};
    vecs[2] = '{16'd305,   16'h0305, 1'b0};
    vecs[3] = '{16'd1200,  16'h1200, 1'b0};
    vecs[4] = '{16'd9999,  16'h9999, 1'b0};
    vecs[5] = '{16'd10000, 16'h0000, 1'b1};
    vecs[6] = '{16'd0,     16'h0000, 1'b0};
    vecs[7] = '{16'd65535, 16'h0000, 1'b1};
    vecs[8] = '{16'd4096,  16'h4096, 1'b0};
    rr_bcd[0] = 16'h0001; rr_bcd[1] = 16'h0022;
    rr_bcd[2] = 16'h0333; rr_bcd[3] = 16'h4444;

    reset = 1'b1;
    src_if.src_valid = '0;
    src_if.src_data  = '0;
    repeat (3) begin @(negedge clk); #1; end
    check("rst_anode", 32'(anode), 32'(4'b0111));
    check("rst_led", 32'(led), 32'(exp_led(2'd0, 16'h0000, 1'b0)));
    check("rst_ack", 32'(src_if.src_ack), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_active", 32'(active_src), 0);
    check("rst_state", 32'(dbg_state), 0);
    reset = 1'b0;

    // round-robin across four requesters
    for (int g = 0; g < 5; g++) exp_q.push_back(2'(g % 4));
    src_if.src_data  = {16'd4444, 16'd333, 16'd22, 16'd1};
    src_if.src_valid = 4'b1111;
    prev_l = 0;
    for (int g = 0; g < 5; g++) begin
      wait_ack(l);
      if (g == 3) src_if.src_valid = 4'b0001;
      if (g == 4) src_if.src_valid = 4'b0000;
      if (g > 0) check("rr_period", l - prev_l, 18 + DWELL + 1);
      prev_l = l;
      wait_until(l + 3);
      check("rr_active", 32'(active_src), g % 4);
      check("rr_busy", 32'(busy), 1);
      wait_until(l + 18);
      check("rr_busy_done", 32'(busy), 0);
      check_cycles("rr", 5, rr_bcd[g % 4], 1'b0);
    end
    prev_bcd = 16'h0001;
    prev_ovf = 1'b0;

    // table-driven single-requester conversions
    for (int v = 0; v < 9; v++) begin
      exp_q.push_back(2'd0);
      src_if.src_data[15:0] = vecs[v].value;
      src_if.src_valid = 4'b0001;
      wait_ack(l);
      src_if.src_valid = 4'b0000;
      wait_until(l + 5);
      check("vec_busy", 32'(busy), 1);
      check("vec_active", 32'(active_src), 0);
      wait_until(l + 17);
      check("vec_busy_in_done", 32'(busy), 1);
      check_cycles("vec_old", 1, prev_bcd, prev_ovf);
      check("vec_busy_after", 32'(busy), 0);
      check_cycles("vec", 16, vecs[v].exp_bcd, vecs[v].exp_ovf);
      prev_bcd = vecs[v].exp_bcd;
      prev_ovf = vecs[v].exp_ovf;
    end

    // requester 2 drops its request during HOLD: no re-grant
    exp_q.push_back(2'd2);
    src_if.src_data[47:32] = 16'd42;
    src_if.src_valid = 4'b0100;
    wait_ack(l);
    wait_until(l + 19);
    src_if.src_valid = 4'b0000;
    wait_until(l + 40);
    check("hold_state_arb", 32'(dbg_state), 0);
    check("hold_active", 32'(active_src), 2);
    check("hold_busy", 32'(busy), 0);
    check("hold_no_regrant", ack_cyc_q.size(), n_acks);
    check_cycles("hold", 16, 16'h0042, 1'b0);

    // reset on the 8th SHIFT cycle
    exp_q.push_back(2'd0);
    src_if.src_data[15:0] = 16'd1234;
    src_if.src_valid = 4'b0001;
    wait_ack(l);
    wait_until(l + 8);
    check("mid_busy", 32'(busy), 1);
    check("mid_state", 32'(dbg_state), 2);
    reset = 1'b1;
    src_if.src_valid = 4'b0000;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_state", 32'(dbg_state), 0);
    check("mid_rst_anode", 32'(anode), 32'(4'b0111));
    check("mid_rst_led", 32'(led), 32'(exp_led(2'd0, 16'h0000, 1'b0)));
    repeat (2) begin @(negedge clk); #1; end
    reset = 1'b0;
    check_cycles("post_rst", 16, 16'h0000, 1'b0);
    check("post_rst_no_ack", ack_cyc_q.size(), n_acks);
    exp_q.push_back(2'd0);
    src_if.src_data  = {16'd3333, 16'd2222, 16'd1111, 16'd2024};
    src_if.src_valid = 4'b1111;
    wait_ack(l);
    src_if.src_valid = 4'b0000;
    wait_until(l + 18);
    check("post_rst_active", 32'(active_src), 0);
    check_cycles("post_rst_val", 16, 16'h2024, 1'b0);

    repeat (30) begin @(negedge clk); #1; end
    check("exp_q_drained", exp_q.size(), 0);
    check("ack_total", ack_cyc_q.size(), n_acks);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/seg_display_scheduler.md
# seg_display_scheduler

Time-shares the 4-digit seven-segment display between up to N_SRC requesters (processor result, PC, debug registers), granting the display round-robin with a fixed dwell time per grant. Each granted 16-bit binary value is converted to BCD by a sequential shift-add-3 engine into a double-buffered digit register. The display is then multiplexed onto the anode/segment pins. It sits between the processor top level and the board display pins, and runs entirely on the 100 MHz board clock.

## Interface
- N_SRC, 4, number of requesters (2..8)
- DWELL_CYCLES, 100000000, cycles a granted value stays displayed before re-arbitration (≥1)
- REFRESH_BITS, 20, digit-refresh counter width; bits [REFRESH_BITS-1:REFRESH_BITS-2] select the digit
- clk_100mhz  in  1  board clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- src_valid  in  N_SRC  per-requester display request; held until acked
- src_data  in  16*N_SRC  binary value of requester i in bits [16i+15:16i]
- src_ack  out  N_SRC  one-cycle pulse: requester's data sampled this cycle
- active_src  out  $clog2(N_SRC)  index of requester currently owning the display
- busy  out  1  high while BCD conversion runs
- Anode_Activate  out  4  active-low digit enables, bit 3 = thousands
- LED_out  out  7  active-low segments, bit 6 = a … bit 0 = g

## Operation
- FSM states: ARB, LOAD, SHIFT, DONE, HOLD. Reset → ARB.
- ARB: search src_valid starting at (last_grant+1) mod N_SRC, wrapping. First set bit wins. None set → stay in ARB; display keeps current digits.
- LOAD: sample src_data of the winner into the shift register, pulse its src_ack, update active_src. Clear the BCD scratch and set busy.
- SHIFT: 16 iterations. Each cycle, add 3 to every BCD nibble ≥5, then shift {bcd,bin} left 1.
- DONE: if the sampled value >9999, set overflow. Copy scratch BCD into the display buffer in one cycle (no torn digits). Clear busy and load the dwell counter with DWELL_CYCLES-1.
- HOLD: decrement the dwell counter; at 0 → ARB. src_valid changes during HOLD are ignored.
- A single active requester is re-granted each dwell period, which refreshes its value.
- Digit mux: the free-running REFRESH_BITS counter selects the digit from its top 2 bits.
  - 00 → anode 4'b0111, thousands
  - 01 → 4'b1011, hundreds
  - 10 → 4'b1101, tens
  - 11 → 4'b1110, ones
- Segment codes 0-9: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.
- Overflow: all four digits show 7'b1111110 (dash) until the next DONE.

## Timing
- Grant latency: ARB → LOAD is 1 cycle; src_ack is asserted in the LOAD cycle.
- Sample-to-display latency: LOAD + 16 SHIFT + DONE = 18 cycles; the display buffer updates on the edge ending DONE.
- Grant period: 18 + DWELL_CYCLES + 1 (ARB) cycles when requests are continuously pending.
- Reset values:
  - src_ack 0, busy 0, active_src 0, last_grant N_SRC-1 (so requester 0 wins first)
  - display buffer 0000, overflow 0, refresh counter 0
  - Anode_Activate 4'b0111
  - LED_out 7'b0000001, or 7'b1111111 with blanking enabled
- Reset asserted mid-conversion or mid-HOLD: abort immediately to reset values; no src_ack is generated.
- The refresh counter wraps freely, independent of the FSM.

## Configuration
- SEG_LEAD_BLANK_EN defined: leading-zero digits output 7'b1111111. Blanking stops at the first nonzero digit; the ones digit is never blanked. Overflow dashes are unaffected.
- Undefined: all four digits are always driven, including leading zeros.

## Test plan
- Reset → Anode_Activate=0111, LED_out=0000001 (blank if SEG_LEAD_BLANK_EN), src_ack=0, busy=0.
- src_valid=0001, src_data[15:0]=6765 → src_ack[0] pulses 1 cycle; display buffer=6,7,6,5 exactly 18 cycles after the LOAD cycle; each digit's segments are correct at its refresh slot.
- src_valid=1111, values 1,22,333,4444, DWELL_CYCLES=4 → grants in order 0,1,2,3,0; active_src and digits track each grant.
- src_data=10000 → all digits dash; a next grant of 0 → 0000 (or blank-blank-blank-0).
- Reset pulsed on the 8th SHIFT cycle → busy=0, buffer=0000, no further src_ack; after release, requester 0 is granted first.
- Only src_valid[2] high; drop it during HOLD → no re-grant after dwell, FSM idles in ARB, digits unchanged.
